// File: rtl/adc_scan_sequencer.sv
`timescale 1ns/1ps
// adc_scan_sequencer
// Steps the analog mux through a channel mask, waits a settling time, pulses
// the ADC trigger and collects one conversion per enabled channel. It supports
// single-shot and continuous scans, and each conversion has a timeout.
//
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          begin a scan (IDLE only)
//   abort          return to IDLE immediately, suppressing results
//   continuous     re-latch chan_mask and rescan after the last channel
//   chan_mask      channels to convert, bit i = channel i
//   err_clr        clears the sticky timeout_err flag
//   adc_done       single-cycle conversion-complete strobe, adc_data valid with it
//   amux_sel       registered mux select
//   adc_trigger    single-cycle conversion start (decoded from state)
//   res_valid      single-cycle result strobe, with res_ch / res_data
//   scan_done      single-cycle pulse at the end of each scan pass
//   busy           state is not IDLE
//   timeout_err    sticky: some conversion timed out
module adc_scan_sequencer #(
  parameter int NUM_CH         = 8,
  parameter int CH_W           = 3,
  parameter int DATA_W         = 32,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] chan_mask,
  input  logic              err_clr,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic [CH_W-1:0]   amux_sel,
  output logic              adc_trigger,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_data,
  output logic              scan_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, TRIG, WAIT} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [NUM_CH-1:0]   mask_rem, mask_n;
  logic [NUM_CH-1:0]   cur_bit, remaining;
  logic [CH_W-1:0]     sel_n, res_ch_n;
  logic [DATA_W-1:0]   res_data_n;
  logic                res_valid_n, scan_done_n, err_set;

  function automatic logic [CH_W-1:0] lowest_bit(input logic [NUM_CH-1:0] m);
    lowest_bit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = CH_W'(i);
    end
  endfunction

  assign adc_trigger = (state == TRIG);
  assign busy        = (state != IDLE);

  // Channels below the current one are already cleared, so whatever is left
  // after dropping the current bit is exactly the set of channels above it.
  always_comb begin
    cur_bit           = '0;
    cur_bit[amux_sel] = 1'b1;
    remaining         = mask_rem & ~cur_bit;
  end

  // Next-state logic. The timeout budget is counted from the trigger cycle,
  // so the counter is loaded on entry to TRIG and already ticks once in TRIG;
  // the advance then lands SETTLE_CYCLES+TIMEOUT_CYCLES edges after the start.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    mask_n      = mask_rem;
    sel_n       = amux_sel;
    res_valid_n = 1'b0;
    res_ch_n    = res_ch;
    res_data_n  = res_data;
    scan_done_n = 1'b0;
    err_set     = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && (chan_mask != '0)) begin
            mask_n  = chan_mask;
            sel_n   = lowest_bit(chan_mask);
            cnt_n   = SETTLE_LOAD;
            state_n = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            cnt_n   = TIMEOUT_LOAD;
            state_n = TRIG;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        TRIG: begin
          state_n = WAIT;
          if (cnt != '0) cnt_n = cnt - CNT_W'(1);
        end
        WAIT: begin
          if (adc_done || (cnt == '0)) begin
            // adc_done takes precedence over a timeout on the same edge
            if (adc_done) begin
              res_valid_n = 1'b1;
              res_ch_n    = amux_sel;
              res_data_n  = adc_data;
            end else begin
              err_set = 1'b1;
            end
            mask_n = remaining;
            if (remaining != '0) begin
              sel_n   = lowest_bit(remaining);
              cnt_n   = SETTLE_LOAD;
              state_n = SETTLE;
            end else begin
              scan_done_n = 1'b1;
              if (continuous && (chan_mask != '0)) begin
                mask_n  = chan_mask;
                sel_n   = lowest_bit(chan_mask);
                cnt_n   = SETTLE_LOAD;
                state_n = SETTLE;
              end else begin
                state_n = IDLE;
              end
            end
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and output registers. A timeout set wins over err_clr on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      mask_rem    <= '0;
      amux_sel    <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_data    <= '0;
      scan_done   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      mask_rem  <= mask_n;
      amux_sel  <= sel_n;
      res_valid <= res_valid_n;
      res_ch    <= res_ch_n;
      res_data  <= res_data_n;
      scan_done <= scan_done_n;
      if (err_set) timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule
